// File: rtl/alu_result_stage.sv
// alu_result_stage: result/flag stage behind the 8-bit ALU.
// Holds the architectural flag register {P,S,C,Z}, feeds carry back to the ALU,
// buffers one writeback entry behind a valid/ready handshake and evaluates
// branch conditions from the stored flags.
// Optional feature macro: ALU_FLAG_SAVE_EN adds a shadow flag register with
// flag_save / flag_restore controls and a saved_flags output.
module alu_result_stage #(
   parameter int          DATA_W   = 8,
   parameter int          ADDR_W   = 3,
   parameter logic [3:0]  FLAG_RST = 4'b0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] alu_out,
   input  logic [3:0]        alu_flags,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic              wb_en,
   input  logic [3:0]        flag_we,
   input  logic [ADDR_W-1:0] dest_addr,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [DATA_W-1:0] wb_data,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [3:0]        flags_q,
`ifdef ALU_FLAG_SAVE_EN
   input  logic              flag_save,
   input  logic              flag_restore,
   output logic [3:0]        saved_flags,
`endif
   output logic              cin_out,
   input  logic [2:0]        cond_sel,
   output logic              cond_true
);

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   wb_data_q, wb_data_d;
   logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
   logic [3:0]          flags_d;
   logic                accept_s;
   logic                load_s;
`ifdef ALU_FLAG_SAVE_EN
   logic [3:0]          shadow_q, shadow_d;
`endif

   // Buffer FSM: ready decode and next state; a drain and a new load may share a cycle.
   always_comb begin
      state_d  = state_q;
      op_ready = 1'b0;
      accept_s = 1'b0;
      load_s   = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            op_ready = 1'b1;
            accept_s = op_valid;
            load_s   = op_valid & wb_en;
            if (load_s) begin
               state_d = ST_FULL;
            end else begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            op_ready = wb_ready;
            accept_s = op_valid & wb_ready;
            load_s   = op_valid & wb_ready & wb_en;
            if (wb_ready) begin
               if (load_s) begin
                  state_d = ST_FULL;
               end else begin
                  state_d = ST_EMPTY;
               end
            end else begin
               state_d = ST_FULL;
            end
         end
         default: begin
            state_d  = ST_EMPTY;
            op_ready = 1'b0;
            accept_s = 1'b0;
            load_s   = 1'b0;
         end
      endcase
   end

   // Writeback payload only changes when a new entry is loaded.
   always_comb begin
      wb_data_d = wb_data_q;
      wb_addr_d = wb_addr_q;
      if (load_s) begin
         wb_data_d = alu_out;
         wb_addr_d = dest_addr;
      end else begin
         wb_data_d = wb_data_q;
         wb_addr_d = wb_addr_q;
      end
   end

   // Flag next value: restore beats an accept; accepts merge under the per-bit mask.
   always_comb begin
      flags_d = flags_q;
`ifdef ALU_FLAG_SAVE_EN
      shadow_d = shadow_q;
      if (flag_save && !flag_restore) begin
         shadow_d = flags_q;
      end else begin
         shadow_d = shadow_q;
      end
      if (flag_restore) begin
         flags_d = shadow_q;
      end else if (accept_s) begin
         flags_d = (flags_q & ~flag_we) | (alu_flags & flag_we);
      end else begin
         flags_d = flags_q;
      end
`else
      if (accept_s) begin
         flags_d = (flags_q & ~flag_we) | (alu_flags & flag_we);
      end else begin
         flags_d = flags_q;
      end
`endif
   end

   // State, payload and flag registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_EMPTY;
         wb_data_q <= {DATA_W{1'b0}};
         wb_addr_q <= {ADDR_W{1'b0}};
         flags_q   <= FLAG_RST;
`ifdef ALU_FLAG_SAVE_EN
         shadow_q  <= FLAG_RST;
`endif
      end else begin
         state_q   <= state_d;
         wb_data_q <= wb_data_d;
         wb_addr_q <= wb_addr_d;
         flags_q   <= flags_d;
`ifdef ALU_FLAG_SAVE_EN
         shadow_q  <= shadow_d;
`endif
      end
   end

   assign wb_valid = (state_q == ST_FULL);
   assign wb_data  = wb_data_q;
   assign wb_addr  = wb_addr_q;
   assign cin_out  = flags_q[1];
`ifdef ALU_FLAG_SAVE_EN
   assign saved_flags = shadow_q;
`endif

   // Branch condition evaluated from the registered flags only.
   always_comb begin
      cond_true = 1'b0;
      case (cond_sel)
         3'd0:    cond_true = 1'b1;
         3'd1:    cond_true = flags_q[0];
         3'd2:    cond_true = ~flags_q[0];
         3'd3:    cond_true = flags_q[1];
         3'd4:    cond_true = ~flags_q[1];
         3'd5:    cond_true = flags_q[2];
         3'd6:    cond_true = ~flags_q[2];
         3'd7:    cond_true = flags_q[3];
         default: cond_true = 1'b0;
      endcase
   end

endmodule
